// File: rtl/ds_scoreboard_ctrl.sv
// ds_scoreboard_ctrl: per-register pending-writer scoreboard generating decode-stage ready_go/issue.
// Optional SB_WB_BYPASS_EN: last outstanding writer retiring this cycle does not stall (write-through regfile).
module ds_scoreboard_ctrl #(
  parameter int CNT_W = 2,
  parameter int NREG  = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ds_valid,
  input  logic            src1_used,
  input  logic [AW-1:0]   src1_addr,
  input  logic            src2_used,
  input  logic [AW-1:0]   src2_addr,
  input  logic            dst_we,
  input  logic [AW-1:0]   dst_addr,
  input  logic            es_allowin,
  input  logic            ws_rf_we,
  input  logic [AW-1:0]   ws_rf_waddr,
  output logic            ds_ready_go,
  output logic            ds_issue,
  output logic [NREG-1:0] busy_vec,
  output logic            sb_err
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             err_q, err_d;
  logic [NREG-1:0]  pend, inc_hit, dec_hit;
  logic             hz1, hz2;
  assign inc_hit = (ds_issue && dst_we && dst_addr != '0) ? (NREG'(1) << dst_addr) : '0;
  assign dec_hit = (ws_rf_we && ws_rf_waddr != '0) ? (NREG'(1) << ws_rf_waddr) : '0;
  always_comb begin
    pend     = '0;
    busy_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_vec[r] = cnt_q[r] != '0;
`ifdef SB_WB_BYPASS_EN
      pend[r] = busy_vec[r] && !(dec_hit[r] && cnt_q[r] == CNT_W'(1));
`else
      pend[r] = busy_vec[r];
`endif
    end
  end
  // Hazard uses pre-issue state, so src == dst of the same instruction only sees older writers.
  assign hz1         = src1_used && src1_addr != '0 && pend[src1_addr];
  assign hz2         = src2_used && src2_addr != '0 && pend[src2_addr];
  assign ds_ready_go = ~(hz1 | hz2);
  assign ds_issue    = ds_valid & ds_ready_go & es_allowin;
  assign sb_err      = err_q;
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (inc_hit[r] && !dec_hit[r]) ? (cnt_q[r] == CMAX ? cnt_q[r] : cnt_q[r] + CNT_W'(1)) :
                 (dec_hit[r] && !inc_hit[r]) ? (cnt_q[r] == '0 ? cnt_q[r] : cnt_q[r] - CNT_W'(1)) :
                 cnt_q[r];
      err_d = err_d | (inc_hit[r] && !dec_hit[r] && cnt_q[r] == CMAX)
                    | (dec_hit[r] && !inc_hit[r] && cnt_q[r] == '0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule
